// File: rtl/nvram_backup_controller.sv
// rtl/nvram_backup_controller.sv - NVRAM restore/backup sequencer between HPS SD-block port and NVRAM port B
module nvram_backup_controller #(
  parameter int unsigned MOUNT_TIMEOUT = 30_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        save_request,
  input  logic        nvram_cpu_changed,
  output logic        nvram_allow_cpu_access,
  output logic [12:0] nvram_backup_restore_adr,
  output logic [7:0]  nvram_restore_data,
  output logic        nvram_restore_write,
  input  logic [7:0]  nvram_backup_data,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        dirty,
  output logic        busy
);

  typedef enum logic [2:0] {
    WAIT_MOUNT, IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER
  } state_t;

  state_t      state;
  logic [3:0]  sec;
  logic [31:0] tmo_cnt;
  logic        ack_q;
  logic [12:0] rd_adr;
  logic        in_xfer;
  logic        ack_fall;
  logic        big_image;

  assign in_xfer   = (state == RD_XFER) || (state == WR_XFER);
  // ack_q is held low outside *_XFER, so a fall is only seen after a rise inside the transfer
  assign ack_fall  = in_xfer && ack_q && !sd_ack;
  assign big_image = (img_size >= 64'd8192);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= WAIT_MOUNT;
      sec                 <= 4'd0;
      tmo_cnt             <= 32'd0;
      ack_q               <= 1'b0;
      dirty               <= 1'b0;
      rd_adr              <= 13'd0;
      nvram_restore_data  <= 8'd0;
      nvram_restore_write <= 1'b0;
    end else begin
      ack_q               <= in_xfer ? sd_ack : 1'b0;
      nvram_restore_write <= (state == RD_XFER) && sd_buff_wr;
      if ((state == RD_XFER) && sd_buff_wr) begin
        rd_adr             <= {sec, sd_buff_addr};
        nvram_restore_data <= sd_buff_dout;
      end

      case (state)
        WAIT_MOUNT, IDLE: begin
          if (img_mounted) begin
            if (big_image) begin
              sec   <= 4'd0;
              dirty <= 1'b0;
              state <= RD_REQ;
            end else begin
              // Too small to hold a backup: mark dirty so the first save writes one
              dirty <= 1'b1;
              state <= IDLE;
            end
          end else if (state == WAIT_MOUNT) begin
            if (tmo_cnt == 32'(MOUNT_TIMEOUT - 1))
              state <= IDLE;
            else
              tmo_cnt <= tmo_cnt + 32'd1;
          end else if (save_request && dirty && !img_readonly) begin
            dirty <= 1'b0;
            sec   <= 4'd0;
            state <= WR_REQ;
          end
        end
        RD_REQ: if (sd_ack) state <= RD_XFER;
        WR_REQ: if (sd_ack) state <= WR_XFER;
        RD_XFER, WR_XFER: begin
          if (ack_fall) begin
            if (sec == 4'd15) begin
              state <= IDLE;
            end else begin
              sec   <= sec + 4'd1;
              state <= (state == RD_XFER) ? RD_REQ : WR_REQ;
            end
          end
        end
        default: state <= WAIT_MOUNT;
      endcase

      // A CPU write in the same cycle as a clear must still leave NVRAM marked dirty
      if (nvram_cpu_changed) dirty <= 1'b1;
    end
  end

  assign sd_lba                   = {28'd0, sec};
  assign sd_rd                    = (state == RD_REQ);
  assign sd_wr                    = (state == WR_REQ);
  assign busy                     = (state != WAIT_MOUNT) && (state != IDLE);
  assign nvram_allow_cpu_access   = (state == IDLE);
  // Backup reads use the live HPS address so port B data lands one cycle later, as the HPS expects
  assign nvram_backup_restore_adr = nvram_restore_write ? rd_adr : {sec, sd_buff_addr};
  assign sd_buff_din              = nvram_backup_data;

endmodule

// File: tb/tb_nvram_backup_controller.sv
// tb/tb_nvram_backup_controller.sv - directed scoreboard bench for nvram_backup_controller
module tb_nvram_backup_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        img_mounted, img_readonly, save_request, nvram_cpu_changed;
  logic [63:0] img_size;
  logic        nvram_allow_cpu_access;
  logic [12:0] nvram_backup_restore_adr;
  logic [7:0]  nvram_restore_data;
  logic        nvram_restore_write;
  logic [7:0]  nvram_backup_data;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout, sd_buff_din;
  logic        dirty, busy;

  logic        cpu_we;
  logic [12:0] cpu_adr;
  logic [7:0]  cpu_data;
  logic [7:0]  mem [0:8191];

  int n_vec = 0;
  int n_err = 0;

  logic [20:0] rq [$];
  logic [7:0]  bq [$];

  always #5 clk = ~clk;

  nvram_backup_controller #(.MOUNT_TIMEOUT(100)) dut (
    .clk(clk), .reset(reset),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .save_request(save_request), .nvram_cpu_changed(nvram_cpu_changed),
    .nvram_allow_cpu_access(nvram_allow_cpu_access),
    .nvram_backup_restore_adr(nvram_backup_restore_adr),
    .nvram_restore_data(nvram_restore_data), .nvram_restore_write(nvram_restore_write),
    .nvram_backup_data(nvram_backup_data),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din), .dirty(dirty), .busy(busy)
  );

  // NVRAM model: port A (CPU) writes from the bench, port B with 1-cycle read latency
  always @(posedge clk) begin
    if (cpu_we) mem[cpu_adr] <= cpu_data;
    else if (nvram_restore_write) mem[nvram_backup_restore_adr] <= nvram_restore_data;
    nvram_backup_data <= mem[nvram_backup_restore_adr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] img_byte(input int s, input int a);
    return 8'(s) ^ 8'(a);
  endfunction

  always @(negedge clk) begin
    if (!reset && nvram_restore_write) begin
      chk("restore_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) chk("restore_adr_data", {11'd0, nvram_backup_restore_adr, nvram_restore_data}, {11'd0, rq.pop_front()});
    end
  end

  task automatic wait_req(input bit wr, input int s);
    int i;
    for (i = 0; i < 50; i++) begin
      if ((wr ? sd_wr : sd_rd) === 1'b1) break;
      @(negedge clk);
    end
    chk(wr ? "wr_req_seen" : "rd_req_seen", 32'(i < 50), 32'd1);
    chk("req_lba", sd_lba, 32'(s));
  endtask

  task automatic watch_no_wr(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      seen |= sd_wr;
    end
  endtask

  task automatic serve_read(input int first, input int last);
    for (int s = first; s <= last; s++) begin
      wait_req(1'b0, s);
      sd_ack = 1'b1;
      @(negedge clk);
      chk("rd_drop_after_ack", 32'(sd_rd), 32'd0);
      for (int a = 0; a < 512; a++) begin
        sd_buff_wr   = 1'b1;
        sd_buff_addr = 9'(a);
        sd_buff_dout = img_byte(s, a);
        rq.push_back({13'(s * 512 + a), img_byte(s, a)});
        @(negedge clk);
      end
      sd_buff_wr = 1'b0;
      @(negedge clk);
      chk("rd_access_during_xfer", 32'(nvram_allow_cpu_access), 32'd0);
      chk("rd_busy_during_xfer", 32'(busy), 32'd1);
      sd_ack = 1'b0;
      @(negedge clk);
      chk("rd_access_after_fall", 32'(nvram_allow_cpu_access), 32'(s == 15));
    end
  endtask

  task automatic serve_write();
    for (int s = 0; s < 16; s++) begin
      wait_req(1'b1, s);
      chk("wr_access_revoked", 32'(nvram_allow_cpu_access), 32'd0);
      sd_ack = 1'b1;
      @(negedge clk);
      chk("wr_drop_after_ack", 32'(sd_wr), 32'd0);
      for (int a = 0; a <= 512; a++) begin
        if (a > 0) chk((s == 1 && a == 6) ? "din_s1_a5" : "backup_din", 32'(sd_buff_din), 32'(bq.pop_front()));
        if (a < 512) begin
          sd_buff_addr = 9'(a);
          bq.push_back((s == 1 && a == 5) ? 8'hA5 : img_byte(s, a));
        end
        @(negedge clk);
      end
      chk("wr_access_during_xfer", 32'(nvram_allow_cpu_access), 32'd0);
      sd_ack = 1'b0;
      @(negedge clk);
      chk("wr_access_after_fall", 32'(nvram_allow_cpu_access), 32'(s == 15));
    end
  endtask

  task automatic pulse_mount(input logic [63:0] size);
    img_size    = size;
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    img_mounted = 1'b0; img_readonly = 1'b0; img_size = 64'd0;
    save_request = 1'b0; nvram_cpu_changed = 1'b0;
    sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = 9'd0; sd_buff_dout = 8'd0;
    cpu_we = 1'b0; cpu_adr = 13'd0; cpu_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_access", 32'(nvram_allow_cpu_access), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dirty", 32'(dirty), 32'd0);
    chk("rst_rd_wr", {30'd0, sd_rd, sd_wr}, 32'd0);
    chk("rst_write", 32'(nvram_restore_write), 32'd0);
    chk("rst_lba", sd_lba, 32'd0);

    // No mount: access granted after exactly 100 cycles
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 99; c++) begin
      @(negedge clk);
      seen |= sd_rd;
    end
    chk("tmo_access_at_99", 32'(nvram_allow_cpu_access), 32'd0);
    @(negedge clk);
    seen |= sd_rd;
    chk("tmo_access_at_100", 32'(nvram_allow_cpu_access), 32'd1);
    chk("tmo_no_sd_rd", 32'(seen), 32'd0);
    chk("tmo_dirty", 32'(dirty), 32'd0);

    // Save with clean NVRAM does nothing
    save_request = 1'b1;
    @(negedge clk);
    save_request = 1'b0;
    watch_no_wr(20, seen);
    chk("clean_save_no_wr", 32'(seen), 32'd0);

    nvram_cpu_changed = 1'b1;
    @(negedge clk);
    nvram_cpu_changed = 1'b0;
    chk("cpu_change_dirty", 32'(dirty), 32'd1);

    // Mount and save in the same cycle: restore wins
    img_size = 64'd8192;
    img_mounted = 1'b1;
    save_request = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
    save_request = 1'b0;
    chk("same_cycle_rd", {30'd0, sd_rd, sd_wr}, 32'd2);
    chk("restore_clears_dirty", 32'(dirty), 32'd0);
    chk("restore_access", 32'(nvram_allow_cpu_access), 32'd0);
    serve_read(0, 15);
    chk("nvram_1234", 32'(mem[13'h1234]), 32'h3D);
    chk("restore_queue_drained", 32'(rq.size()), 32'd0);
    chk("restore_dirty_end", 32'(dirty), 32'd0);
    chk("restore_busy_end", 32'(busy), 32'd0);

    // CPU modifies NVRAM, read-only image suppresses backup
    cpu_we = 1'b1; cpu_adr = 13'h205; cpu_data = 8'hA5;
    nvram_cpu_changed = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
    nvram_cpu_changed = 1'b0;
    chk("cpu_change_dirty2", 32'(dirty), 32'd1);
    img_readonly = 1'b1;
    save_request = 1'b1;
    @(negedge clk);
    save_request = 1'b0;
    watch_no_wr(20, seen);
    chk("readonly_no_wr", 32'(seen), 32'd0);
    chk("readonly_dirty_kept", 32'(dirty), 32'd1);

    img_readonly = 1'b0;
    save_request = 1'b1;
    @(negedge clk);
    save_request = 1'b0;
    chk("backup_dirty_cleared", 32'(dirty), 32'd0);
    serve_write();
    chk("backup_dirty_end", 32'(dirty), 32'd0);
    chk("backup_queue_drained", 32'(bq.size()), 32'd0);

    // Reset while sector 7 of a restore is being requested
    pulse_mount(64'd8192);
    serve_read(0, 6);
    wait_req(1'b0, 7);
    chk("pre_reset_sd_rd", 32'(sd_rd), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid_reset_sd_rd", 32'(sd_rd), 32'd0);
    chk("mid_reset_access", 32'(nvram_allow_cpu_access), 32'd0);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    chk("mid_reset_lba", sd_lba, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulse_mount(64'd8192);
    chk("remount_rd", 32'(sd_rd), 32'd1);
    chk("remount_lba0", sd_lba, 32'd0);
    serve_read(0, 15);
    chk("nvram_205_restored", 32'(mem[13'h205]), 32'h04);
    chk("nvram_1234_again", 32'(mem[13'h1234]), 32'h3D);
    chk("restore2_queue_drained", 32'(rq.size()), 32'd0);

    // Image smaller than NVRAM: no restore, marked dirty
    pulse_mount(64'd8191);
    chk("small_img_busy", 32'(busy), 32'd0);
    chk("small_img_access", 32'(nvram_allow_cpu_access), 32'd1);
    chk("small_img_dirty", 32'(dirty), 32'd1);
    chk("small_img_no_rd", 32'(sd_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nvram_backup_controller.md
# nvram_backup_controller

Sequencer between the MiSTer HPS SD-block interface and the 8 KiB NVRAM port B (backup/restore side) of the timekeeper NVRAM. On image mount it restores 16 × 512-byte sectors into NVRAM and then grants CPU access. On an OSD save request it writes NVRAM back to the image if the CPU has modified it. It owns `nvram_allow_cpu_access`, so CPU accesses stall (no bus_ack) during restore and backup.

## Interface
- `MOUNT_TIMEOUT`, default 30_000_000: clk cycles to wait for a mount after reset before granting CPU access without a restore.
- `clk  in  1`: system clock.
- `reset  in  1`: asynchronous, active-high.
- `img_mounted  in  1`: pulse; image (re)mounted.
- `img_readonly  in  1`: image is read-only; backup is suppressed.
- `img_size  in  64`: image size in bytes.
- `save_request  in  1`: level or pulse; request a backup.
- `nvram_cpu_changed  in  1`: pulse; CPU wrote NVRAM.
- `nvram_allow_cpu_access  out  1`: CPU may access NVRAM.
- `nvram_backup_restore_adr  out  13`: NVRAM port B address.
- `nvram_restore_data  out  8`: NVRAM port B write data.
- `nvram_restore_write  out  1`: NVRAM port B write enable.
- `nvram_backup_data  in  8`: NVRAM port B read data (1-cycle latency).
- `sd_lba  out  32`: sector number.
- `sd_rd  out  1`: sector read request.
- `sd_wr  out  1`: sector write request.
- `sd_ack  in  1`: HPS transfer active.
- `sd_buff_addr  in  9`: byte index within the sector.
- `sd_buff_dout  in  8`: read data from HPS.
- `sd_buff_wr  in  1`: sd_buff_dout is valid.
- `sd_buff_din  out  8`: write data to HPS.
- `dirty  out  1`: NVRAM differs from the image.
- `busy  out  1`: a restore or backup is in progress.

## Operation
- States: WAIT_MOUNT, IDLE, RD_REQ, RD_XFER, WR_REQ, WR_XFER. A 4-bit sector counter `sec`.
- `sd_lba` = {28'b0, sec}. `nvram_allow_cpu_access` = 1 only in IDLE. `busy` = state ∉ {WAIT_MOUNT, IDLE}.
- **WAIT_MOUNT** (reset state):
  - On `img_mounted`: if `img_size` ≥ 8192, set sec = 0 and go to RD_REQ. Otherwise go to IDLE with `dirty` = 1 (a fresh image gets written on the first save).
  - Timeout counter reaching `MOUNT_TIMEOUT`-1: go to IDLE.
- **IDLE**:
  - `img_mounted` is handled as in WAIT_MOUNT (re-restore).
  - Otherwise `save_request` && `dirty` && !`img_readonly`: clear `dirty`, set sec = 0, go to WR_REQ.
  - `img_mounted` has priority over `save_request` in the same cycle.
- **RD_REQ**: `sd_rd` = 1 until `sd_ack` is sampled high, then go to RD_XFER.
  - `sd_rd` drops the cycle after `sd_ack` is first seen high.
- **RD_XFER**: each `sd_buff_wr` registers the NVRAM write for the next cycle:
  - `nvram_backup_restore_adr` = {sec, sd_buff_addr}
  - `nvram_restore_data` = `sd_buff_dout`
  - `nvram_restore_write` = 1
- **Sector completion**: on `sd_ack` falling (registered edge detect), if sec == 15 go to IDLE; else increment sec and return to the *_REQ state.
- **WR_REQ / WR_XFER**: same handshake with `sd_wr`. Port B address is combinational {sec, sd_buff_addr}; `sd_buff_din` = `nvram_backup_data`. This satisfies the HPS one-cycle buffer read latency.
- **dirty**:
  - Set by `nvram_cpu_changed` in any state. A set in the same cycle as a clear wins.
  - Cleared on entry to RD_REQ, since a restore makes NVRAM match the image.
- Outside RD_XFER: `nvram_restore_write` = 0, and `nvram_backup_restore_adr` follows the WR rule (harmless reads).

## Timing
- Reset values: state WAIT_MOUNT, sec 0, all outputs 0, timeout counter 0.
- Reset mid-transfer: `sd_rd`/`sd_wr` drop immediately (asynchronous) and CPU access is revoked. The HPS transfer is abandoned.
- Restore write latency: 1 cycle from `sd_buff_wr` to `nvram_restore_write`.
- Backup read path: 0-cycle address, 1-cycle data, matching the port B RAM.
- Full restore or backup: 16 ack pulses. CPU access is granted the cycle after the 16th `sd_ack` fall.
- `sd_ack` already high when a *_REQ state is entered: it is accepted the next cycle.
- `sd_ack` glitch: a fall without a preceding rise in the *_XFER state is ignored, because the edge detector is only armed in *_XFER.

## Test plan
- **Restore after mount:** reset, then mount with img_size = 8192; HPS serves sector n with byte = n ^ addr[7:0].
  - NVRAM[0x1234] = 0x09 ^ 0x34.
  - `nvram_allow_cpu_access` rises the cycle after the 16th ack fall.
  - `dirty` = 0.
- **No mount:** `MOUNT_TIMEOUT` = 100, no mount → access granted at cycle 100, no `sd_rd` ever seen.
- **Backup of a CPU change:** `nvram_cpu_changed` pulse, then `save_request` → 16 `sd_wr` sectors, lba 0..15.
  - `sd_buff_din` at sector 1, addr 5 equals NVRAM[0x205].
  - `dirty` = 0; access revoked throughout the backup.
- **Suppressed backups:**
  - `save_request` with `dirty` = 0 → no `sd_wr`.
  - With `img_readonly` = 1 and `dirty` = 1 → no `sd_wr`; `dirty` stays 1.
- **Same-cycle events:** `img_mounted` and `save_request` in the same IDLE cycle → a restore (`sd_rd`) starts, not a backup.
- **Reset during transfer:** reset asserted during sector 7 of a restore → `sd_rd` = 0, state WAIT_MOUNT, access = 0.
  - A new mount restarts at lba 0.
